// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the branch prediction/resolution controller.
// Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
package branch_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = BHT_WNT;

endpackage

// File: rtl/branch_hist_table.sv
// Table of 2-bit saturating counters: combinational read, clocked update.
// Reads in the same cycle as a write see the pre-update value.
module branch_hist_table
    import branch_ctrl_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bht_state_e       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int DEPTH = 2 ** IDX_W;

    bht_state_e r_ctr [DEPTH];
    bht_state_e w_cur;
    bht_state_e w_nxt;

    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = r_ctr[i_wr_idx];

    always_comb begin
        w_nxt = w_cur;
        unique case (w_cur)
            BHT_SNT: w_nxt = i_wr_taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: w_nxt = i_wr_taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  w_nxt = i_wr_taken ? BHT_ST  : BHT_WNT;
            BHT_ST:  w_nxt = i_wr_taken ? BHT_ST  : BHT_WT;
            default: w_nxt = BHT_RESET;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= BHT_RESET;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_nxt;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch predict (ID) / resolve (EX) controller with redirect and flush.
// Define BRANCH_CTRL_STATS_EN to add branch and mispredict counters.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int BHT_IDX_W = 6
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_id_valid,
    input  logic        i_id_is_br,
    input  logic        i_id_is_jal,
    input  logic [31:0] i_id_pc,
    input  logic [31:0] i_id_target,
    output logic        o_id_pred_taken,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jalr,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush_ifid,
`ifdef BRANCH_CTRL_STATS_EN
    output logic        o_flush_idex,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
`else
    output logic        o_flush_idex
`endif
);

    bht_state_e  w_rd_ctr;
    logic        w_taken;
    logic        w_ex_br;
    logic        w_ex_jalr;
    logic        w_ex_mispred;
    logic [31:0] w_ex_redir_pc;
    logic        w_bht_wr;
    logic        w_unused;

    // Only the index bits of the ID PC matter here
    assign w_unused = ^{i_id_pc[31:BHT_IDX_W+2], i_id_pc[1:0]};

    branch_hist_table #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rd_idx   (i_id_pc[BHT_IDX_W+1:2]),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_bht_wr),
        .i_wr_idx   (i_ex_pc[BHT_IDX_W+1:2]),
        .i_wr_taken (w_taken)
    );

    assign o_br_un = i_ex_funct3[1];

    always_comb begin
        w_taken = 1'b0;
        case (i_ex_funct3)
            F3_BEQ:           w_taken = i_br_equal;
            F3_BNE:           w_taken = ~i_br_equal;
            F3_BLT, F3_BLTU:  w_taken = i_br_less;
            F3_BGE, F3_BGEU:  w_taken = ~i_br_less;
            default:          w_taken = 1'b0;
        endcase
    end

    assign o_id_pred_taken = i_id_valid &
                             (i_id_is_jal | (i_id_is_br & w_rd_ctr[1]));

    assign w_ex_br      = i_ex_valid & i_ex_is_br;
    assign w_ex_jalr    = i_ex_valid & i_ex_is_jalr;
    assign w_ex_mispred = (w_ex_br & (w_taken != i_ex_pred_taken)) |
                          w_ex_jalr;
    assign w_bht_wr     = w_ex_br & ~i_stall;

    always_comb begin
        if (w_ex_jalr)
            w_ex_redir_pc = {i_ex_target[31:1], 1'b0};
        else if (w_taken)
            w_ex_redir_pc = i_ex_target;
        else
            w_ex_redir_pc = i_ex_pc + 32'd4;
    end

    // EX correction is older than the ID prediction, so it wins
    always_comb begin
        o_redirect    = 1'b0;
        o_redirect_pc = 32'd0;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        if (w_ex_mispred) begin
            o_redirect    = 1'b1;
            o_redirect_pc = w_ex_redir_pc;
            o_flush_ifid  = 1'b1;
            o_flush_idex  = 1'b1;
        end else if (o_id_pred_taken) begin
            o_redirect    = 1'b1;
            o_redirect_pc = i_id_target;
            o_flush_ifid  = 1'b1;
        end
    end

`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_br_count      <= 32'd0;
            r_mispred_count <= 32'd0;
        end else if (!i_stall) begin
            if (w_ex_br | w_ex_jalr)
                r_br_count <= r_br_count + 32'd1;
            if (w_ex_mispred)
                r_mispred_count <= r_mispred_count + 32'd1;
        end
    end

    assign o_br_count      = r_br_count;
    assign o_mispred_count = r_mispred_count;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized and directed bench for branch_ctrl against a behavioural model.
// Stats ports are exercised when BRANCH_CTRL_STATS_EN is defined.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_valid, id_is_br, id_is_jal;
    logic [31:0] id_pc, id_target;
    logic        id_pred;
    logic        ex_valid, ex_is_br, ex_is_jalr;
    logic [2:0]  ex_f3;
    logic [31:0] ex_pc, ex_target;
    logic        ex_pred;
    logic        br_un, br_less, br_equal;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_ifid, flush_idex;
`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] br_count, mispred_count;
    logic [31:0] m_br_cnt, m_mis_cnt;
`endif

    int m_ctr [64];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_stall         (stall),
        .i_id_valid      (id_valid),
        .i_id_is_br      (id_is_br),
        .i_id_is_jal     (id_is_jal),
        .i_id_pc         (id_pc),
        .i_id_target     (id_target),
        .o_id_pred_taken (id_pred),
        .i_ex_valid      (ex_valid),
        .i_ex_is_br      (ex_is_br),
        .i_ex_is_jalr    (ex_is_jalr),
        .i_ex_funct3     (ex_f3),
        .i_ex_pc         (ex_pc),
        .i_ex_target     (ex_target),
        .i_ex_pred_taken (ex_pred),
        .o_br_un         (br_un),
        .i_br_less       (br_less),
        .i_br_equal      (br_equal),
        .o_redirect      (redirect),
        .o_redirect_pc   (redirect_pc),
        .o_flush_ifid    (flush_ifid),
`ifdef BRANCH_CTRL_STATS_EN
        .o_flush_idex    (flush_idex),
        .o_br_count      (br_count),
        .o_mispred_count (mispred_count)
`else
        .o_flush_idex    (flush_idex)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic bit m_taken(input logic [2:0] f, input bit lt,
                                   input bit eq);
        case (f)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
`ifdef BRANCH_CTRL_STATS_EN
        m_br_cnt  = 0;
        m_mis_cnt = 0;
`endif
    endtask

    task automatic clr();
        stall = 0; id_valid = 0; id_is_br = 0; id_is_jal = 0;
        id_pc = 0; id_target = 0; ex_valid = 0; ex_is_br = 0;
        ex_is_jalr = 0; ex_f3 = 0; ex_pc = 0; ex_target = 0;
        ex_pred = 0; br_less = 0; br_equal = 0;
    endtask

    // Check combinational outputs, then advance one clock and the model
    task automatic step(input string tag);
        bit pred, tk, mis, ebr, ejalr;
        logic [31:0] rpc;
        int ix;
        #1;
        pred  = id_valid && (id_is_jal ||
                (id_is_br && m_ctr[int'(id_pc[7:2])] >= 2));
        tk    = m_taken(ex_f3, br_less, br_equal);
        ebr   = ex_valid && ex_is_br;
        ejalr = ex_valid && ex_is_jalr;
        mis   = (ebr && (tk != ex_pred)) || ejalr;
        if (mis) rpc = ejalr ? (ex_target & ~32'd1)
                             : (tk ? ex_target : ex_pc + 32'd4);
        else if (pred) rpc = id_target;
        else rpc = 32'd0;
        chk({tag, ".pred"}, {31'd0, id_pred}, {31'd0, pred});
        chk({tag, ".un"}, {31'd0, br_un}, {31'd0, ex_f3[1]});
        chk({tag, ".redir"}, {31'd0, redirect}, {31'd0, mis || pred});
        chk({tag, ".rpc"}, redirect_pc, rpc);
        chk({tag, ".fifid"}, {31'd0, flush_ifid}, {31'd0, mis || pred});
        chk({tag, ".fidex"}, {31'd0, flush_idex}, {31'd0, mis});
`ifdef BRANCH_CTRL_STATS_EN
        chk({tag, ".brcnt"}, br_count, m_br_cnt);
        chk({tag, ".miscnt"}, mispred_count, m_mis_cnt);
`endif
        @(posedge clk);
        if (!rst && !stall) begin
            if (ebr) begin
                ix = int'(ex_pc[7:2]);
                m_ctr[ix] = tk ? (m_ctr[ix] == 3 ? 3 : m_ctr[ix] + 1)
                               : (m_ctr[ix] == 0 ? 0 : m_ctr[ix] - 1);
            end
`ifdef BRANCH_CTRL_STATS_EN
            if (ebr || ejalr) m_br_cnt++;
            if (mis) m_mis_cnt++;
`endif
        end
        @(negedge clk);
    endtask

    task automatic id_br(input logic [31:0] pc, input logic [31:0] tgt);
        id_valid = 1; id_is_br = 1; id_is_jal = 0;
        id_pc = pc; id_target = tgt;
    endtask

    task automatic ex_br(input logic [2:0] f, input logic [31:0] pc,
                         input logic [31:0] tgt, input bit p,
                         input bit lt, input bit eq);
        ex_valid = 1; ex_is_br = 1; ex_is_jalr = 0; ex_f3 = f;
        ex_pc = pc; ex_target = tgt; ex_pred = p;
        br_less = lt; br_equal = eq;
    endtask

    initial begin
        clr();
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        step("rst");
        rst = 0;
        step("idle");

        // Cold BEQ predicts not taken, resolves taken
        id_br(32'h100, 32'h180);
        step("beq_id0");
        clr();
        ex_br(3'b000, 32'h100, 32'h180, 0, 0, 1);
        step("beq_ex0");
        clr();
        id_br(32'h100, 32'h180);
        step("beq_id1");
        clr();
        ex_br(3'b000, 32'h100, 32'h180, 1, 0, 1);
        step("beq_ex1");
        ex_br(3'b000, 32'h100, 32'h180, 1, 0, 1);
        step("beq_ex2");
        clr();
        id_br(32'h100, 32'h180);
        step("beq_id2");

        // BLTU not taken with PC wrap on fall-through
        clr();
        ex_br(3'b110, 32'hFFFF_FFFC, 32'h40, 1, 0, 0);
        step("bltu_wrap");

        // EX mispredict beats ID JAL
        ex_br(3'b001, 32'h200, 32'h300, 0, 0, 0);
        id_valid = 1; id_is_jal = 1; id_pc = 32'h400; id_target = 32'h500;
        step("ex_vs_jal");

        // Stall: outputs live, table frozen
        clr();
        stall = 1;
        ex_br(3'b100, 32'h140, 32'h1C0, 0, 1, 0);
        step("stall_br");
        clr();
        id_br(32'h140, 32'h1C0);
        step("stall_id");
        clr();
        ex_valid = 1; ex_is_jalr = 1; ex_target = 32'h203; ex_pc = 32'h44;
        step("jalr");

        // Random traffic over a small set of indices to train counters
        for (int n = 0; n < 400; n++) begin
            int k;
            clr();
            stall = ($urandom % 8) == 0;
            k = $urandom % 4;
            id_valid  = k != 0;
            id_is_br  = k == 1 || k == 2;
            id_is_jal = k == 3;
            id_pc     = ($urandom & 32'hFFFF_FF00) | (($urandom % 8) << 2);
            id_target = $urandom;
            k = $urandom % 5;
            ex_valid   = k != 0;
            ex_is_br   = k == 1 || k == 2 || k == 3;
            ex_is_jalr = k == 4;
            ex_f3      = 3'($urandom);
            ex_pc      = (($urandom % 16) == 0) ? 32'hFFFF_FFFC :
                         (($urandom & 32'hFFFF_FF00) | (($urandom % 8) << 2));
            ex_target  = $urandom;
            ex_pred    = 1'($urandom);
            br_less    = 1'($urandom);
            br_equal   = 1'($urandom);
            step("rand");
        end

        // Mid-run reset restores WNT everywhere and clears stats
        clr();
        rst = 1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            id_br(32'h1000 | (i << 2), 32'h2000 + i);
            step("mrst");
        end
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            id_br(32'h1000 | (i << 2), 32'h2000 + i);
            step("post_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch prediction and resolution controller for the 5-stage pipeline. Predicts conditional branches in ID using a table of 2-bit saturating counters, drives the unsigned/signed select of the EX-stage branch comparator, evaluates its less/equal outputs against funct3, and on misprediction issues the PC redirect and pipeline flushes. Sits between the decoder, the EX-stage comparator and the PC/pipeline-register control.

## Interface
- BHT_IDX_W, 6, index width; table has 2**BHT_IDX_W entries indexed by pc[BHT_IDX_W+1:2]
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_stall  in  1  pipeline stall; freezes table and statistics updates
- i_id_valid, i_id_is_br, i_id_is_jal  in  1 each  ID-stage instruction class
- i_id_pc, i_id_target  in  32 each  ID PC and computed branch/JAL target
- o_id_pred_taken  out  1  prediction, carried down the pipe to EX
- i_ex_valid, i_ex_is_br, i_ex_is_jalr  in  1 each  EX-stage instruction class
- i_ex_funct3  in  3  branch funct3
- i_ex_pc, i_ex_target  in  32 each  EX PC and resolved target
- i_ex_pred_taken  in  1  prediction made in ID for this instruction
- o_br_un  out  1  unsigned-compare select to comparator
- i_br_less, i_br_equal  in  1 each  comparator results
- o_redirect  out  1  load PC from o_redirect_pc at next edge
- o_redirect_pc  out  32  redirect address
- o_flush_ifid, o_flush_idex  out  1 each  squash pipeline registers

## Operation
- o_br_un = i_ex_funct3[1]. Taken: 000 equal, 001 !equal, 100/110 less, 101/111 !less; 010/011 not taken.
- ID prediction: o_id_pred_taken = i_id_valid & (i_id_is_jal | (i_id_is_br & counter[idx][1])).
- EX resolve (i_ex_valid & i_ex_is_br): mispredict = taken != i_ex_pred_taken. Redirect target: i_ex_target if taken, else i_ex_pc+4 (32-bit wrap).
- JALR (i_ex_valid & i_ex_is_jalr): always mispredict, target = i_ex_target with bit 0 cleared.
- EX mispredict: o_redirect=1, o_flush_ifid=1, o_flush_idex=1; ID prediction is ignored that cycle.
- Else ID predicted taken: o_redirect=1, o_redirect_pc=i_id_target, o_flush_ifid=1, o_flush_idex=0.
- Else all redirect/flush outputs 0, o_redirect_pc=0.
- Counter update on resolved conditional branch, !i_stall: taken → saturating increment, not taken → saturating decrement (00 SNT, 01 WNT, 10 WT, 11 ST).
- Outputs with i_stall high are still driven; only state updates are suppressed.

## Timing
- Prediction, comparator select, redirect and flushes: combinational, same cycle as inputs.
- Table read combinational; write at rising edge. Same-index read and write in one cycle: read returns pre-update value.
- Reset: all counters 01 (WNT); all outputs derive from inputs, so with i_id_valid=i_ex_valid=0 every output is 0.
- Reset asserted mid-operation: counters return to 01 immediately, statistics to 0.

## Configuration
- BRANCH_CTRL_STATS_EN defined: adds outputs o_br_count and o_mispred_count (32 bits each, reset 0, wrap at 2**32). Increment on each resolved conditional branch/JALR, and on each EX mispredict, when !i_stall.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package branch_ctrl_pkg: funct3 constants (BEQ..BGEU), 2-bit counter state enum, reset counter value.
- Sub-module branch_hist_table: counter array, async reset, combinational read port, saturating update port.

## Test plan
- After reset, BEQ at 0x100 in ID → o_id_pred_taken=0; in EX with equal=1 → redirect to i_ex_target, both flushes 1, counter 01→10.
- Same BEQ again → predicted taken in ID (redirect to target, flush_ifid only); resolves taken in EX → no redirect, counter 10→11, then stays 11.
- BLTU with funct3 110 → o_br_un=1; less=0 with pred_taken=1 → redirect to i_ex_pc+4; i_ex_pc=0xFFFFFFFC → redirect 0x00000000.
- Simultaneous EX mispredict and ID JAL → EX target wins, both flushes 1.
- i_stall=1 with resolved branch → redirect still asserted, counter unchanged; JALR target 0x203 → redirect 0x202.
- Reset asserted mid-run after training entries → all counters 01, stats (if BRANCH_CTRL_STATS_EN) 0.
